// File: rtl/ex_div_ctrl.sv
// Radix-2 restoring divide sequencer for the RV32M DIV/DIVU/REM/REMU group.
// Produces one quotient bit per clock and returns a registered result with a one-cycle ready pulse.
module ex_div_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  annul_i,
   input  logic [2:0]            funct3_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   output logic                  stallreq_o,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q,  state_d;
   logic [CNT_W-1:0]        count_q,  count_d;
   logic [DATA_WIDTH-1:0]   rem_q,    rem_d;
   logic [DATA_WIDTH-1:0]   quot_q,   quot_d;
   logic [DATA_WIDTH-1:0]   dvsr_q,   dvsr_d;
   logic                    is_rem_q, is_rem_d;
   logic                    q_neg_q,  q_neg_d;
   logic                    r_neg_q,  r_neg_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic                    ready_q,  ready_d;

   logic signed [DATA_WIDTH-1:0] dvd_s;
   logic signed [DATA_WIDTH-1:0] dvs_s;
   logic                         accept;
   logic                         signed_op;
   logic [DATA_WIDTH:0]          shifted;
   logic [DATA_WIDTH:0]          trial;
   logic [DATA_WIDTH-1:0]        rem_step;
   logic [DATA_WIDTH-1:0]        quot_step;

   function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v,
                                                    input logic              neg);
      return neg ? ((~v) + ONE) : v;
   endfunction

   // Magnitude of a two's-complement value; the most negative value maps to 2^(W-1) unsigned.
   function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic signed [DATA_WIDTH-1:0] x);
      logic [DATA_WIDTH-1:0] u;
      u = x;
      return neg_if(u, x < 0);
   endfunction

   assign dvd_s     = dividend_i;
   assign dvs_s     = divisor_i;
   assign accept    = start_i & ~annul_i & funct3_i[2];
   assign signed_op = ~funct3_i[0];

   // One restoring step: partial remainder < divisor keeps the shifted value within W+1 bits.
   assign shifted   = {rem_q, quot_q[DATA_WIDTH-1]};
   assign trial     = shifted - {1'b0, dvsr_q};
   assign rem_step  = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
   assign quot_step = {quot_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      dvsr_d     = dvsr_q;
      is_rem_d   = is_rem_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      result_d   = result_q;
      ready_d    = 1'b0;
      stallreq_o = 1'b0;

      case (state_q)
         IDLE: begin
            stallreq_o = accept;
            if (accept) begin
               is_rem_d = funct3_i[1];
               q_neg_d  = signed_op & ((dvd_s < 0) ^ (dvs_s < 0));
               r_neg_d  = signed_op & (dvd_s < 0);
               quot_d   = signed_op ? abs_mag(dvd_s) : dividend_i;
               dvsr_d   = signed_op ? abs_mag(dvs_s) : divisor_i;
               rem_d    = '0;
               count_d  = '0;
               if (divisor_i == '0) begin
                  result_d = funct3_i[1] ? dividend_i : '1;
                  ready_d  = 1'b1;
                  state_d  = DONE;
               end else begin
                  state_d  = BUSY;
               end
            end
         end
         BUSY: begin
            stallreq_o = 1'b1;
            rem_d      = rem_step;
            quot_d     = quot_step;
            count_d    = count_q + CNT_ONE;
            if (count_q == CNT_LAST) begin
               result_d = is_rem_q ? neg_if(rem_step, r_neg_q) : neg_if(quot_step, q_neg_q);
               ready_d  = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A flush wins over everything, including a same-cycle start.
      if (annul_i) begin
         state_d  = IDLE;
         result_d = '0;
         ready_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         dvsr_q   <= '0;
         is_rem_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         dvsr_q   <= dvsr_d;
         is_rem_q <= is_rem_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign ready_o  = ready_q;
   assign result_o = result_q;

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
- Multi-cycle divide sequencer for the RV32M DIV/DIVU/REM/REMU group. Sits beside the execute stage.
- Accepts an operand pair from ex and runs a radix-2 restoring divide, one quotient bit per clock.
- Raises a stall request to the pipeline control while busy and returns a registered result with a one-cycle ready pulse.
- Owns the iteration counter, sign fix-up and special-case shortcuts, so the ex stage only muxes the result in.

Parameters:
- DATA_WIDTH, 32, operand/result width (counter width = clog2(DATA_WIDTH)+1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- start_i  in  1  ex stage holds a divide-group op; held high until ready_o seen.
- annul_i  in  1  pipeline flush; abort any operation.
- funct3_i  in  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; other codes are not divides.
- dividend_i  in  DATA_WIDTH  rs1 value.
- divisor_i  in  DATA_WIDTH  rs2 value.
- stallreq_o  out  1  combinational stall request to pipeline control.
- ready_o  out  1  registered; one-cycle pulse, result_o valid.
- result_o  out  DATA_WIDTH  registered quotient or remainder.

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, count=0, remainder/quotient regs=0.
  - result_o=0, ready_o=0.
  - stallreq_o=0 in the next evaluated cycle.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept when start_i=1, annul_i=0 and funct3_i[2]=1; else stay, no stall.
  - On accept, latch funct3.
  - Signed ops (DIV/REM): latch absolute values of both operands, q_neg = sign(dividend) xor sign(divisor), r_neg = sign(dividend). Unsigned ops: raw operands, no negation.
  - If divisor_i==0 → DONE; result = all-ones for DIV/DIVU, dividend_i unmodified for REM/REMU.
  - Else → BUSY, count=0, partial remainder=0.
- BUSY, each cycle:
  - Shift {rem,quot} left 1.
  - Trial = rem − divisor (DATA_WIDTH+1 bits). If non-negative, rem=trial and quot[0]=1.
  - count++. When count reaches DATA_WIDTH−1 on the last iteration → DONE.
  - Exactly DATA_WIDTH BUSY cycles.
- Transition into DONE registers the result:
  - DIV/DIVU: quot, negated (two's complement) if q_neg.
  - REM/REMU: rem, negated if r_neg.
  - ready_o=1 for the DONE cycle only.
- DONE → IDLE unconditionally next clock; ready_o returns 0.
  - result_o holds its value until the next DONE or annul.
  - A start_i seen in IDLE after DONE is a new instruction.
- Overflow (DIV 0x80000000 / −1) needs no special path: the unsigned magnitude 2^31 over 1 negates to 0x80000000, remainder 0.
- stallreq_o = (IDLE & start_i & funct3_i[2] & ~annul_i) | BUSY; 0 in DONE.
- Latency, start seen at edge T:
  - Normal: DONE/ready at T+DATA_WIDTH+1 (T+33).
  - Divide by zero: T+1.
- annul_i=1 in any state:
  - Next clock state=IDLE, result_o=0; no ready_o pulse for the aborted op.
  - annul_i overrides start_i the same cycle.
- Operand inputs are sampled only on accept; changes during BUSY are ignored.
- Reset asserted mid-BUSY aborts immediately; no ready_o after release.

Test Plan:
- DIVU 100/7 start at T → stallreq_o high T..T+32, ready_o pulse at T+33, result_o=14. REMU same operands → 2.
- DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD. REM same → 0xFFFFFFFF. DIV 7 / −2 → 0xFFFFFFFD. REM 7 / −2 → 1.
- Divide by zero:
  - DIVU 5/0 → ready_o at T+1, result 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0 → 0xFFFFFFFF.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+33. REM → 0.
- annul_i pulsed on 10th BUSY cycle:
  - Next cycle IDLE, stallreq_o=0, result_o=0, no ready_o.
  - Following DIVU 9/3 → 3 at +33.
- Reset and invalid ops:
  - rst low mid-BUSY → outputs 0 asynchronously, no ready_o after release.
  - start_i with funct3=000 → no stall, no ready.
  - Back-to-back DIVU 0xFFFFFFFF/1 then REMU 10/3 → 0xFFFFFFFF then 1, each with 33-cycle latency.
